// File: rtl/engine_sequencer_if.sv
// Request/response handshake between a requester and the engine sequencer.
// The requester drives the master side; the sequencer exposes the slave side.
interface engine_sequencer_if;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_mask;
    logic       resp_valid;
    logic       resp_ready;
    logic [3:0] resp_status;

    modport master (
        output req_valid,
        output req_mask,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp_status
    );

    modport slave (
        input  req_valid,
        input  req_mask,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp_status
    );
endinterface

// File: rtl/engine_sequencer.sv
// Launches the engines selected by a request mask one at a time in priority order 1,2,3.
// Each engine is guarded by a watchdog; a single status word reports timeouts and abort.
module engine_sequencer #(
    parameter int TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    engine_sequencer_if.slave   req_if,
    input  logic                abort,
    output logic                start1,
    output logic                start2,
    output logic                start3,
    input  logic                done1,
    input  logic                done2,
    input  logic                done3,
    output logic                busy,
    output logic [1:0]          cur_engine
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_REPORT = 2'd3
    } state_e;

    // Engine number (1..3) of the highest-priority selected engine; 0 when none.
    function automatic logic [1:0] lowest_engine(input logic [2:0] mask);
        logic [1:0] eng;
        if (mask[0]) begin
            eng = 2'd1;
        end else if (mask[1]) begin
            eng = 2'd2;
        end else if (mask[2]) begin
            eng = 2'd3;
        end else begin
            eng = 2'd0;
        end
        return eng;
    endfunction

    function automatic logic [2:0] engine_bit(input logic [1:0] eng);
        logic [2:0] onehot;
        case (eng)
            2'd1:    onehot = 3'b001;
            2'd2:    onehot = 3'b010;
            2'd3:    onehot = 3'b100;
            default: onehot = 3'b000;
        endcase
        return onehot;
    endfunction

    state_e        state_q, state_d;
    logic [2:0]    pending_q, pending_d;
    logic [1:0]    active_q, active_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    status_q, status_d;

    logic          req_ready_q, req_ready_d;
    logic          busy_q, busy_d;
    logic [2:0]    start_q, start_d;
    logic [1:0]    cur_engine_q, cur_engine_d;
    logic          resp_valid_q, resp_valid_d;
    logic [3:0]    resp_status_q, resp_status_d;

    logic          accept_s;
    logic          done_sel_s;
    state_e        after_engine_s;

    assign accept_s       = (state_q == ST_IDLE) && req_if.req_valid && req_ready_q;
    assign after_engine_s = (pending_q != 3'b000) ? ST_LAUNCH : ST_REPORT;

    // Only the active engine's done line is observed.
    always_comb begin
        case (active_q)
            2'd1:    done_sel_s = done1;
            2'd2:    done_sel_s = done2;
            2'd3:    done_sel_s = done3;
            default: done_sel_s = 1'b0;
        endcase
    end

    // Next-state and datapath register updates.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        timer_d   = timer_q;
        status_d  = status_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    pending_d = req_if.req_mask;
                    status_d  = 4'b0000;
                    state_d   = (req_if.req_mask == 3'b000) ? ST_REPORT : ST_LAUNCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                pending_d = pending_q & ~engine_bit(active_q);
                timer_d   = {TW{1'b0}};
                if (abort) begin
                    status_d[3] = 1'b1;
                    pending_d   = 3'b000;
                    state_d     = ST_REPORT;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                timer_d = timer_q + TIMER_ONE;
                // Abort beats done, and done beats an expiring watchdog.
                if (abort) begin
                    status_d[3] = 1'b1;
                    pending_d   = 3'b000;
                    state_d     = ST_REPORT;
                end else if (done_sel_s) begin
                    state_d = after_engine_s;
                end else if (timer_q == TIMER_LAST) begin
                    status_d = status_q | {1'b0, engine_bit(active_q)};
                    state_d  = after_engine_s;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_REPORT: begin
                if (resp_valid_q && req_if.resp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_REPORT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d == ST_LAUNCH) begin
            active_d = lowest_engine(pending_d);
        end else begin
            active_d = active_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pending_q <= 3'b000;
            active_q  <= 2'd0;
            timer_q   <= {TW{1'b0}};
            status_q  <= 4'b0000;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            active_q  <= active_d;
            timer_q   <= timer_d;
            status_q  <= status_d;
        end
    end

    // Output decode from the upcoming state so every output comes straight from a flop.
    always_comb begin
        req_ready_d  = (state_d == ST_IDLE);
        busy_d       = (state_d != ST_IDLE);
        resp_valid_d = (state_d == ST_REPORT);
        if (state_d == ST_LAUNCH) begin
            start_d = engine_bit(active_d);
        end else begin
            start_d = 3'b000;
        end
        if ((state_d == ST_LAUNCH) || (state_d == ST_WAIT)) begin
            cur_engine_d = active_d;
        end else begin
            cur_engine_d = 2'd0;
        end
        if (state_d == ST_REPORT) begin
            resp_status_d = status_d;
        end else begin
            resp_status_d = 4'b0000;
        end
    end

    // Output registers; all clear on reset, so req_ready rises only after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready_q   <= 1'b0;
            busy_q        <= 1'b0;
            start_q       <= 3'b000;
            cur_engine_q  <= 2'd0;
            resp_valid_q  <= 1'b0;
            resp_status_q <= 4'b0000;
        end else begin
            req_ready_q   <= req_ready_d;
            busy_q        <= busy_d;
            start_q       <= start_d;
            cur_engine_q  <= cur_engine_d;
            resp_valid_q  <= resp_valid_d;
            resp_status_q <= resp_status_d;
        end
    end

    assign req_if.req_ready   = req_ready_q;
    assign req_if.resp_valid  = resp_valid_q;
    assign req_if.resp_status = resp_status_q;
    assign start1             = start_q[0];
    assign start2             = start_q[1];
    assign start3             = start_q[2];
    assign busy               = busy_q;
    assign cur_engine         = cur_engine_q;

endmodule

// File: tb/tb_engine_sequencer.sv
// Bench for engine_sequencer: hand-derived vector table, reset cases and randomized
// transactions checked against a timeline model of the sequencing rules.
module tb_engine_sequencer;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       abort;
    logic       start1, start2, start3;
    logic       done1, done2, done3;
    logic       busy;
    logic [1:0] cur_engine;

    engine_sequencer_if bus ();

    engine_sequencer #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_if     (bus),
        .abort      (abort),
        .start1     (start1),
        .start2     (start2),
        .start3     (start3),
        .done1      (done1),
        .done2      (done2),
        .done3      (done3),
        .busy       (busy),
        .cur_engine (cur_engine)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [2:0] exp_start [0:255];
    logic [1:0] exp_cur   [0:255];
    int         m_rep;
    logic [3:0] m_status;

    typedef struct {
        logic [2:0] mask;
        int d1, d2, d3;
        int ab;
        int rdelay;
        int stray1;
        int e_s1, e_s2, e_s3;
        int e_rep;
        logic [3:0] e_stat;
    } vec_t;

    vec_t tv [10];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Timeline model: cycle numbers count from 1 = first cycle after acceptance.
    // dN in 1..TO = done in the dN-th wait cycle; anything else = never (timeout).
    task automatic model_txn(input logic [2:0] mask, input int d1, input int d2,
                             input int d3, input int ab);
        int t;
        int dk;
        int w;
        bit stop;
        bit tmo;
        for (int i = 0; i < 256; i++) begin
            exp_start[i] = 3'b000;
            exp_cur[i]   = 2'd0;
        end
        t = 1;
        stop = 1'b0;
        m_status = 4'b0000;
        m_rep = -1;
        for (int k = 1; k <= 3; k++) begin
            if (!stop && mask[k-1]) begin
                dk = (k == 1) ? d1 : (k == 2) ? d2 : d3;
                exp_start[t][k-1] = 1'b1;
                exp_cur[t] = 2'(k);
                if (ab == t) begin
                    m_status[3] = 1'b1;
                    m_rep = t + 1;
                    stop = 1'b1;
                end else begin
                    tmo = !(dk >= 1 && dk <= TO);
                    w = tmo ? TO : dk;
                    for (int j = 1; j <= w; j++) begin
                        if (!stop) begin
                            exp_cur[t+j] = 2'(k);
                            if (ab == t + j) begin
                                m_status[3] = 1'b1;
                                m_rep = t + j + 1;
                                stop = 1'b1;
                            end
                        end
                    end
                    if (!stop) begin
                        if (tmo) m_status[k-1] = 1'b1;
                        t = t + w + 1;
                    end
                end
            end
        end
        if (!stop) m_rep = t;
    endtask

    // Issue one request, play reactive engines, check each cycle against the model,
    // then complete the response handshake after rdelay stalled cycles.
    task automatic run_txn(input logic [2:0] mask, input int d1, input int d2, input int d3,
                           input int ab, input int rdelay, input bit noise, input int stray1,
                           output int st1, output int st2, output int st3,
                           output int rep, output logic [3:0] stat);
        int s [3];
        int guard;
        guard = 0;
        while (bus.req_ready !== 1'b1 && guard < 20) begin
            step();
            guard++;
        end
        chk("req_ready_before_req", {31'b0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1;
        bus.req_mask  = mask;
        step();
        bus.req_valid = 1'b0;
        bus.req_mask  = 3'($urandom);
        for (int i = 0; i < 3; i++) s[i] = -1;
        rep = -1;
        stat = 4'b0000;
        for (int c = 1; c <= 100 && rep < 0; c++) begin
            chk("start_vec", {29'b0, start3, start2, start1}, {29'b0, exp_start[c]});
            chk("cur_engine", {30'b0, cur_engine}, {30'b0, exp_cur[c]});
            chk("busy", {31'b0, busy}, 32'd1);
            chk("req_ready_busy", {31'b0, bus.req_ready}, 32'd0);
            if (start1 === 1'b1 && s[0] < 0) s[0] = c;
            if (start2 === 1'b1 && s[1] < 0) s[1] = c;
            if (start3 === 1'b1 && s[2] < 0) s[2] = c;
            if (bus.resp_valid === 1'b1) begin
                rep = c;
                stat = bus.resp_status;
            end else begin
                abort = (c == ab);
                done1 = (s[0] > 0 && c == s[0] + d1) || (stray1 > 0 && c >= stray1)
                        || (noise && !mask[0] && $urandom_range(0, 1) == 1);
                done2 = (s[1] > 0 && c == s[1] + d2)
                        || (noise && !mask[1] && $urandom_range(0, 1) == 1);
                done3 = (s[2] > 0 && c == s[2] + d3)
                        || (noise && !mask[2] && $urandom_range(0, 1) == 1);
                step();
            end
        end
        if (rep < 0) chk("report_reached", 32'd0, 32'd1);
        done1 = 1'b0;
        done2 = 1'b0;
        done3 = 1'b0;
        for (int i = 0; i < rdelay; i++) begin
            abort = noise && ($urandom_range(0, 1) == 1);
            bus.resp_ready = 1'b0;
            step();
            chk("resp_held_valid", {31'b0, bus.resp_valid}, 32'd1);
            chk("resp_held_status", {28'b0, bus.resp_status}, {28'b0, stat});
            chk("req_ready_in_report", {31'b0, bus.req_ready}, 32'd0);
        end
        abort = 1'b0;
        bus.resp_ready = 1'b1;
        step();
        bus.resp_ready = 1'b0;
        chk("idle_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        chk("idle_busy", {31'b0, busy}, 32'd0);
        chk("idle_req_ready", {31'b0, bus.req_ready}, 32'd1);
        st1 = s[0];
        st2 = s[1];
        st3 = s[2];
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, {31'b0, bus.req_ready}, 32'd0);
        chk({tag, "_starts"}, {29'b0, start3, start2, start1}, 32'd0);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_cur_engine"}, {30'b0, cur_engine}, 32'd0);
        chk({tag, "_resp_valid"}, {31'b0, bus.resp_valid}, 32'd0);
        chk({tag, "_resp_status"}, {28'b0, bus.resp_status}, 32'd0);
    endtask

    initial begin
        int st1, st2, st3, rep;
        logic [3:0] stat;
        logic [2:0] rmask;
        int rd1, rd2, rd3, rab, rdl;

        //        mask    d1 d2 d3 ab rdl str  s1  s2  s3 rep stat
        tv[0] = '{3'b010, 0, 3, 0, 0, 0, 0,  -1,  1, -1,  5, 4'b0000};
        tv[1] = '{3'b111, 1, 1, 1, 0, 0, 0,   1,  3,  5,  7, 4'b0000};
        tv[2] = '{3'b101, 0, 0, 2, 0, 1, 0,   1, -1, 10, 13, 4'b0001};
        tv[3] = '{3'b001, 8, 0, 0, 0, 0, 0,   1, -1, -1, 10, 4'b0000};
        tv[4] = '{3'b011, 0, 1, 0, 3, 5, 0,   1, -1, -1,  4, 4'b1000};
        tv[5] = '{3'b000, 0, 0, 0, 0, 0, 0,  -1, -1, -1,  1, 4'b0000};
        tv[6] = '{3'b110, 0, 0, 0, 0, 2, 0,  -1,  1, 10, 19, 4'b0110};
        tv[7] = '{3'b100, 0, 0, 0, 1, 0, 0,  -1, -1,  1,  2, 4'b1000};
        tv[8] = '{3'b111, 1, 0, 0, 12, 1, 0,  1,  3, 12, 13, 4'b1010};
        tv[9] = '{3'b111, 1, 1, 3, 0, 0, 5,   1,  3,  5,  9, 4'b0000};

        rst_n = 1'b1;
        abort = 1'b0;
        done1 = 1'b0;
        done2 = 1'b0;
        done3 = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_mask   = 3'b000;
        bus.resp_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("por");
        step();
        chk_reset_outputs("por_held");
        rst_n = 1'b1;
        step();
        chk("por_release_req_ready", {31'b0, bus.req_ready}, 32'd1);

        for (int i = 0; i < 10; i++) begin
            model_txn(tv[i].mask, tv[i].d1, tv[i].d2, tv[i].d3, tv[i].ab);
            run_txn(tv[i].mask, tv[i].d1, tv[i].d2, tv[i].d3, tv[i].ab, tv[i].rdelay,
                    1'b0, tv[i].stray1, st1, st2, st3, rep, stat);
            chk($sformatf("vec%0d_start1", i), st1, tv[i].e_s1);
            chk($sformatf("vec%0d_start2", i), st2, tv[i].e_s2);
            chk($sformatf("vec%0d_start3", i), st3, tv[i].e_s3);
            chk($sformatf("vec%0d_report_cycle", i), rep, tv[i].e_rep);
            chk($sformatf("vec%0d_status", i), {28'b0, stat}, {28'b0, tv[i].e_stat});
        end

        // Reset in the middle of engine 1's wait window.
        bus.req_valid = 1'b1;
        bus.req_mask  = 3'b111;
        step();
        bus.req_valid = 1'b0;
        step();
        step();
        #3 rst_n = 1'b0;
        #1 chk_reset_outputs("mid_rst");
        step();
        rst_n = 1'b1;
        step();
        chk("mid_rst_release_req_ready", {31'b0, bus.req_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mid_rst_no_start", {29'b0, start3, start2, start1}, 32'd0);
            chk("mid_rst_no_resp", {31'b0, bus.resp_valid}, 32'd0);
        end

        for (int n = 0; n < 40; n++) begin
            rmask = 3'($urandom);
            rd1 = $urandom_range(0, TO + 2);
            rd2 = $urandom_range(0, TO + 2);
            rd3 = $urandom_range(0, TO + 2);
            rab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : 0;
            rdl = $urandom_range(0, 3);
            model_txn(rmask, rd1, rd2, rd3, rab);
            run_txn(rmask, rd1, rd2, rd3, rab, rdl, 1'b1, 0, st1, st2, st3, rep, stat);
            chk("rand_report_cycle", rep, m_rep);
            chk("rand_status", {28'b0, stat}, {28'b0, m_status});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule

// File: doc/engine_sequencer.md
# engine_sequencer

Issues start pulses to the three shared-resource engines and waits for each one's done, one engine at a time. It drives the start1..3 / done1..3 handshake that the resource-select controller monitors. Each accepted request carries a 3-bit engine mask; the block launches the selected engines in fixed priority order (1, then 2, then 3), guards each one with a watchdog timeout, and returns a single status response.

## Interface
- TIMEOUT, default 1024: maximum number of WAIT cycles allowed per engine before a timeout is declared; must be ≥ 2.
- clk  in  1: clock, all logic on rising edge.
- rst_n  in  1: asynchronous active-low reset.
- req_valid  in  1: request present.
- req_ready  out  1: block can accept a request; high only in IDLE.
- req_mask  in  3: bit k-1 selects engine k; sampled on acceptance (req_valid & req_ready).
- abort  in  1: abandons the current sequence; honoured in LAUNCH and WAIT.
- start1, start2, start3  out  1 each: one-cycle start pulses.
- done1, done2, done3  in  1 each: engine completion pulses or levels; only the active engine's done is observed.
- busy  out  1: high in LAUNCH, WAIT and REPORT.
- cur_engine  out  2: 01, 10 or 11 for engine 1/2/3 while in LAUNCH or WAIT; 00 otherwise.
- resp_valid  out  1: response available; held high until accepted.
- resp_ready  in  1: response consumer ready.
- resp_status  out  4: bits [2:0] are per-engine timeout flags (bit k-1 = engine k); bit 3 = aborted; stable while resp_valid is high.

## Operation
- States: IDLE, LAUNCH, WAIT, REPORT. Reset puts the block in IDLE.
- Registers: pending[2:0], active[1:0], timer (width clog2(TIMEOUT+1)), status[3:0].
- **IDLE**
  - req_ready = 1.
  - On acceptance: pending ← req_mask, status ← 0.
  - If req_mask == 0, go to REPORT; otherwise go to LAUNCH.
- **LAUNCH** (one cycle)
  - active = lowest set bit of pending.
  - start_active = 1, cur_engine = active.
  - Clear that bit of pending and set timer ← 0.
  - Go to WAIT.
  - done inputs are ignored in this cycle.
- **WAIT**
  - cur_engine = active. timer increments by 1 each cycle.
  - If done_active = 1: go to LAUNCH if pending ≠ 0, else go to REPORT.
  - Else if timer == TIMEOUT-1: set status[active-1] and take the same pending-based transition (the timed-out engine is abandoned).
  - If done and timeout expiry coincide, done wins and no flag is set.
  - done on non-active engines is ignored.
- **abort** (in LAUNCH or WAIT)
  - status[3] ← 1, pending ← 0, go to REPORT.
  - Abort takes priority over done and timeout in the same cycle.
  - In LAUNCH, the start pulse of that cycle is still emitted.
  - abort has no effect in IDLE or REPORT.
- **REPORT**
  - resp_valid = 1 and resp_status = status.
  - On resp_valid & resp_ready, go to IDLE.
- All outputs are Moore, decoded from registered state.
- Reset values: req_ready = 0 during reset, then 1 in IDLE after reset release. start1..3 = 0, busy = 0, cur_engine = 00, resp_valid = 0, resp_status = 0.
- Reset asserted mid-sequence returns the block to IDLE immediately; no start pulse or response is produced afterwards.

## Timing
- Request accepted at edge T; start pulse is high in cycle T+1; WAIT begins in cycle T+2.
- Minimum turnaround per engine is 2 cycles, when done is high in the first WAIT cycle. Next LAUNCH (or REPORT) follows in the cycle after done is sampled.
- Three engines each doing immediate done: starts in cycles T+1, T+3, T+5; REPORT in cycle T+7.
- Timeout: an engine that never signals done occupies exactly TIMEOUT WAIT cycles.
- Response with resp_ready held high: resp_valid is high for 1 cycle; IDLE follows, and req_ready is high in the next cycle.
- There is no back-to-back bypass: at least one IDLE cycle separates two requests.

## Test plan
- **Reset:** assert rst_n = 0 asynchronously mid-cycle -> all outputs immediately match their reset values; after release, req_ready = 1.
- **Single engine:** req_mask = 3'b010; done2 in the 3rd WAIT cycle -> start2 is high for exactly 1 cycle; cur_engine = 10 from LAUNCH to the end of WAIT; resp_status = 4'b0000.
- **All engines, immediate done:** req_mask = 3'b111, done asserted in the first WAIT cycle each time -> start1/start2/start3 appear in cycles T+1/T+3/T+5; resp_valid in T+7; resp_status = 0. Stray done1 asserted while engine 3 is active -> ignored.
- **Timeout:** TIMEOUT = 8, req_mask = 3'b101, engine 1 never signals done -> after 8 WAIT cycles start3 fires; engine 3 completes -> resp_status = 4'b0001.
- **Done/timeout collision:** TIMEOUT = 8, done1 asserted in the 8th WAIT cycle -> no flag is set.
- **Abort and response backpressure:** req_mask = 3'b011, abort asserted during engine 1's WAIT -> start2 never fires; resp_status = 4'b1000; resp_valid is held for 5 cycles with resp_ready = 0; req_ready stays 0 until the response is accepted.
- **Empty mask:** req_mask = 3'b000 -> no start pulses; resp_valid in cycle T+1 with resp_status = 0.
